// File: rtl/axis_packet_tx.sv
// AXI-Stream packet source: reads REQ_LEN+1 words from a 1-cycle-latency buffer and emits one packet.
// Optional completed-packet counter on PKT_CNT when AXIS_TX_PKT_COUNT_EN is defined.
module axis_packet_tx #(
  parameter int DATAW = 32,
  parameter int IDW   = 4,
  parameter int USERW = 4,
  parameter int DESTW = 4,
  parameter int ADDRW = 10,
  parameter int LENW  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [ADDRW-1:0]  REQ_ADDR,
  input  logic [LENW-1:0]   REQ_LEN,
  input  logic [IDW-1:0]    REQ_ID,
  input  logic [USERW-1:0]  REQ_USER,
  input  logic [DESTW-1:0]  REQ_DEST,
  output logic              MEM_RD_EN,
  output logic [ADDRW-1:0]  MEM_RD_ADDR,
  input  logic [DATAW-1:0]  MEM_RD_DATA,
  output logic              AXIS_M_TVALID,
  input  logic              AXIS_M_TREADY,
  output logic [DATAW-1:0]  AXIS_M_TDATA,
  output logic              AXIS_M_TLAST,
  output logic [IDW-1:0]    AXIS_M_TID,
  output logic [USERW-1:0]  AXIS_M_TUSER,
  output logic [DESTW-1:0]  AXIS_M_TDEST,
  output logic [31:0]       PKT_CNT
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t            state, state_nx;
  logic [IDW-1:0]    id_q;
  logic [USERW-1:0]  user_q;
  logic [DESTW-1:0]  dest_q;
  logic [ADDRW-1:0]  rd_addr;
  logic [LENW:0]     issue_left;
  logic              inflight, inflight_last;
  logic [DATAW-1:0]  fifo_data [2];
  logic [1:0]        fifo_last;
  logic              wr_ptr, rd_ptr;
  logic [1:0]        fifo_cnt;
  logic              accept, pop, push;
  logic [2:0]        occupancy;

  assign pop       = AXIS_M_TVALID && AXIS_M_TREADY;
  assign push      = inflight;
  // Words already owed to the FIFO after this cycle's pop; a read may issue only if room remains.
  assign occupancy = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};

  assign AXIS_M_TVALID = (fifo_cnt != 2'd0);
  assign AXIS_M_TDATA  = fifo_data[rd_ptr];
  assign AXIS_M_TLAST  = AXIS_M_TVALID && fifo_last[rd_ptr];
  assign AXIS_M_TID    = id_q;
  assign AXIS_M_TUSER  = user_q;
  assign AXIS_M_TDEST  = dest_q;
  assign MEM_RD_ADDR   = rd_addr;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    REQ_READY = 1'b0;
    MEM_RD_EN = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        REQ_READY = !RST;
        if (REQ_VALID && !RST) begin
          accept   = 1'b1;
          state_nx = STREAM;
        end
      end
      STREAM: begin
        if (issue_left != '0 && occupancy < 3'd2 && !RST) MEM_RD_EN = 1'b1;
        if (pop && AXIS_M_TLAST) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      id_q          <= '0;
      user_q        <= '0;
      dest_q        <= '0;
      rd_addr       <= '0;
      issue_left    <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      fifo_cnt      <= '0;
      fifo_last     <= '0;
      for (int unsigned i = 0; i < 2; i++) fifo_data[i] <= '0;
    end else begin
      inflight      <= MEM_RD_EN;
      inflight_last <= MEM_RD_EN && (issue_left == (LENW+1)'(1));
      if (accept) begin
        rd_addr    <= REQ_ADDR;
        issue_left <= {1'b0, REQ_LEN} + (LENW+1)'(1);
        id_q       <= REQ_ID;
        user_q     <= REQ_USER;
        dest_q     <= REQ_DEST;
      end else if (MEM_RD_EN) begin
        rd_addr    <= rd_addr + ADDRW'(1);
        issue_left <= issue_left - (LENW+1)'(1);
      end
      if (push) begin
        fifo_data[wr_ptr] <= MEM_RD_DATA;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

`ifdef AXIS_TX_PKT_COUNT_EN
  logic [31:0] pkt_cnt;
  always_ff @(posedge CLK) begin
    if (RST)                       pkt_cnt <= '0;
    else if (pop && AXIS_M_TLAST)  pkt_cnt <= pkt_cnt + 32'd1;
  end
  assign PKT_CNT = pkt_cnt;
`else
  assign PKT_CNT = '0;
`endif

endmodule
